// File: rtl/serial_divider_pkg.sv
// serial_divider_pkg
//   Shared constants for the serial restoring divider: state encoding and
//   the default operand width.
`timescale 1ns/100ps
package serial_divider_pkg;

  localparam int SDIV_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sdiv_state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit full subtractor (a - b - bi), gate-level.
//   Ports: a (minuend), b (subtrahend), bi (borrow in),
//          d (difference), bo (borrow out).
//   Optional: SERIAL_DIVIDER_SPECIFY_EN adds pin-to-pin path delays.
`timescale 1ns/100ps
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic a_n, t0, t1, t2, t3;

  xor g_x0 (t0, a, b);
  xor g_x1 (d, t0, bi);
  not g_n0 (a_n, a);
  and g_a0 (t1, a_n, b);
  and g_a1 (t2, a_n, bi);
  and g_a2 (t3, b, bi);
  or  g_o0 (bo, t1, t2, t3);

`ifdef SERIAL_DIVIDER_SPECIFY_EN
  specify
    (a => d)  = (2, 2.4);
    (a => bo) = (1.4, 1.6);
  endspecify
`endif

endmodule

// File: rtl/serial_divider.sv
// serial_divider
//   Sequential restoring unsigned divider, one quotient bit per clock.
//   Ports:
//     clk, rst_n        - clock, async active-low reset
//     start             - request; accepted in IDLE or DONE, ignored in CALC
//     dividend, divisor - operands, sampled with an accepted start
//     busy              - high while iterating (CALC)
//     done              - one-cycle result-valid pulse (DONE)
//     quotient,
//     remainder         - results, held until the next accepted start
//     div_by_zero       - divisor was zero; held until the next accepted start
//   Optional: SERIAL_DIVIDER_SPECIFY_EN adds clk->output path delays.
`timescale 1ns/100ps
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH = SDIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  sdiv_state_e      state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // Shifted partial remainder and ripple subtraction T - {0, D}.
  logic [WIDTH:0]   t_val;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] bor;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  // R never exceeds D after a step, so its top bit is carried but never read.
  logic unused_r_msb;
  assign unused_r_msb = r_q[WIDTH];

  assign t_val  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign sub_b  = {1'b0, d_q};
  assign bor[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_subtractor u_fs (
      .a  (t_val[i]),
      .b  (sub_b[i]),
      .bi (bor[i]),
      .d  (diff[i]),
      .bo (bor[i+1])
    );
  end

  // Borrow out means T < D: restore (keep T) and shift in a 0.
  assign r_next = bor[WIDTH+1] ? t_val : diff;
  assign q_next = {q_q[WIDTH-2:0], ~bor[WIDTH+1]};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      CALC: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = q_next;
          rem_d   = r_next[WIDTH-1:0];
        end
      end
      default: begin
        // IDLE and DONE both accept start; DONE falls back to IDLE otherwise.
        if (state_q == DONE) state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = {1'b0, dividend};
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = CW'(WIDTH - 1);
            dbz_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

`ifdef SERIAL_DIVIDER_SPECIFY_EN
  specify
    (clk => busy)         = (0.5, 0.6);
    (clk => done)         = (0.5, 0.6);
    (clk *> quotient)     = (0.5, 0.6);
    (clk *> remainder)    = (0.5, 0.6);
    (clk => div_by_zero)  = (0.5, 0.6);
  endspecify
`endif

endmodule

// File: tb/tb_serial_divider.sv
// tb_serial_divider
//   Directed-vector bench for serial_divider at WIDTH = 8.
`timescale 1ns/100ps
module tb_serial_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  serial_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Present operands with start for one edge; returns 1ns after that edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Edges elapsed until done is seen (sampled 1ns after each edge), bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_start(8'd100, 8'd7);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles (done=%b) expected 8", cyc, done);
    end
    n_checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b expected 14 2 0 0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL basic_hold: got done=%b q=%0d r=%0d expected 0 14 2",
               done, quotient, remainder);
    end
  endtask

  task automatic test_edges();
    int cyc;
    do_start(8'd255, 8'd1);
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || quotient !== 8'd255 || remainder !== 8'd0) begin
      n_fail++;
      $display("FAIL div_255_1: got cyc=%0d q=%0d r=%0d expected 8 255 0",
               cyc, quotient, remainder);
    end
    do_start(8'd5, 8'd9);
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || quotient !== 8'd0 || remainder !== 8'd5) begin
      n_fail++;
      $display("FAIL div_5_9: got cyc=%0d q=%0d r=%0d expected 8 0 5",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_start(8'd42, 8'd0);
    wait_done(cyc);
    n_checks++;
    if (cyc != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_latency: got cyc=%0d busy=%b expected 0 0", cyc, busy);
    end
    n_checks++;
    if (quotient !== 8'hFF || remainder !== 8'd42 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: got q=%h r=%0d dbz=%b expected ff 42 1",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_hold: got done=%b dbz=%b expected 0 1", done, div_by_zero);
    end
    do_start(8'd42, 8'd6);
    n_checks++;
    if (div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_clear: got dbz=%b expected 0", div_by_zero);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || quotient !== 8'd7 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_42_6: got cyc=%0d q=%0d r=%0d dbz=%b expected 8 7 0 0",
               cyc, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    int n_done;
    do_start(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    do_start(8'd9, 8'd9);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_busy: got %b expected 1", busy);
    end
    wait_done(cyc);
    // 4 edges already elapsed since the accepted start.
    n_checks++;
    if (cyc != 4 || quotient !== 8'd66 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL ign_result: got cyc=%0d q=%0d r=%0d expected 4 66 2",
               cyc, quotient, remainder);
    end
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_extra_done: got %0d extra pulses busy=%b expected 0 0", n_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [3] = '{8'd20, 8'd4, 8'd20};
    logic [W-1:0] exp_r [3] = '{8'd0, 8'd1, 8'd0};
    // First result WIDTH edges after the start; then start is re-accepted in
    // each DONE cycle, giving one result every WIDTH+1 edges.
    int exp_gap [3] = '{8, 9, 9};
    int cyc;
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        wait_done(cyc);
      end else begin
        @(posedge clk);
        #1;
        wait_done(cyc);
        cyc = cyc + 1;
      end
      n_checks++;
      if (done !== 1'b1 || cyc != exp_gap[k] || quotient !== exp_q[k] || remainder !== exp_r[k]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got done=%b gap=%0d q=%0d r=%0d expected 1 %0d %0d %0d",
                 k, done, cyc, quotient, remainder, exp_gap[k], exp_q[k], exp_r[k]);
      end
      if (k % 2 == 0) begin
        dividend = 8'd17;
        divisor  = 8'd4;
      end else begin
        dividend = 8'd200;
        divisor  = 8'd10;
      end
      if (k == 2) start = 1'b0;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    int n_done;
    do_start(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %b expected all zero",
               {busy, done, quotient, remainder, div_by_zero});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", n_done);
    end
    do_start(8'd100, 8'd7);
    wait_done(cyc);
    n_checks++;
    if (cyc != 8 || quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL abort_rerun: got cyc=%0d q=%0d r=%0d expected 8 14 2",
               cyc, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
